// File: rtl/gemmini_tile_pkg.sv
// Shared types and widths for the Gemmini PE tile feed sequencer.
package gemmini_tile_pkg;

  localparam int unsigned A_W     = 8;
  localparam int unsigned BD_W    = 20;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned LEN_W   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StResp
  } seq_state_e;

  typedef struct packed {
    logic               dataflow;
    logic               propagate;
    logic [SHIFT_W-1:0] shift;
  } tile_ctrl_t;

  // Fields latched at command accept; preload acts on prop immediately and is not kept.
  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic               dataflow;
    logic [SHIFT_W-1:0] shift;
    logic [ID_W-1:0]    id;
  } tile_cmd_t;

endpackage

// File: rtl/tile_seq_watchdog.sv
// Saturating drain watchdog: counts enabled cycles from a clear, flags Timeout-1 reached.
module tile_seq_watchdog #(
  parameter int unsigned Timeout = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CntW'(Timeout - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tile_feed_sequencer.sv
// Sequences one PE tile matmul: merges A and B/D streams into tile beats, waits for the
// matching last output, then returns a completion response.
module tile_feed_sequencer
  import gemmini_tile_pkg::*;
#(
  parameter int unsigned Timeout = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [LEN_W-1:0]   cmd_len_i,
  input  logic               cmd_preload_i,
  input  logic               cmd_dataflow_i,
  input  logic [SHIFT_W-1:0] cmd_shift_i,
  input  logic [ID_W-1:0]    cmd_id_i,
  input  logic               a_valid_i,
  output logic               a_ready_o,
  input  logic [A_W-1:0]     a_data_i,
  input  logic               bd_valid_i,
  output logic               bd_ready_o,
  input  logic [BD_W-1:0]    bd_b_i,
  input  logic [BD_W-1:0]    bd_d_i,
  output logic               tile_in_valid_o,
  output logic [A_W-1:0]     tile_in_a_o,
  output logic [BD_W-1:0]    tile_in_b_o,
  output logic [BD_W-1:0]    tile_in_d_o,
  output logic               tile_in_dataflow_o,
  output logic               tile_in_propagate_o,
  output logic [SHIFT_W-1:0] tile_in_shift_o,
  output logic [ID_W-1:0]    tile_in_id_o,
  output logic               tile_in_last_o,
  input  logic               tile_out_valid_i,
  input  logic               tile_out_last_i,
  input  logic [ID_W-1:0]    tile_out_id_i,
  input  logic               tile_bad_dataflow_i,
  output logic               done_valid_o,
  input  logic               done_ready_i,
  output logic [ID_W-1:0]    done_id_o,
  output logic               done_error_o,
  output logic               busy_o
);

  seq_state_e       state_q, state_d;
  tile_cmd_t        cmd_q, cmd_d;
  logic             prop_q, prop_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             tin_valid_q;
  logic [A_W-1:0]   tin_a_q;
  logic [BD_W-1:0]  tin_b_q, tin_d_q;
  tile_ctrl_t       tin_ctrl_q;
  logic [ID_W-1:0]  tin_id_q;
  logic             tin_last_q;

  logic beat_fire, out_match, wdog_expired, last_beat;

  // Both streams pop together; ready is derived from valid, never the other way round.
  assign beat_fire = (state_q == StStream) && a_valid_i && bd_valid_i;
  assign last_beat = (cnt_q == cmd_q.len);
  assign out_match = tile_out_valid_i && tile_out_last_i && (tile_out_id_i == cmd_q.id);

  assign cmd_ready_o = (state_q == StIdle);
  assign a_ready_o   = beat_fire;
  assign bd_ready_o  = beat_fire;
  assign busy_o      = (state_q != StIdle);

  assign done_valid_o = (state_q == StResp);
  assign done_id_o    = cmd_q.id;
  assign done_error_o = err_q;

  tile_seq_watchdog #(
    .Timeout (Timeout)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (state_q != StDrain),
    .en_i      (state_q == StDrain),
    .expired_o (wdog_expired)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    prop_d  = prop_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          cmd_d.len      = cmd_len_i;
          cmd_d.dataflow = cmd_dataflow_i;
          cmd_d.shift    = cmd_shift_i;
          cmd_d.id       = cmd_id_i;
          err_d          = 1'b0;
          cnt_d          = '0;
          if (cmd_preload_i) prop_d = ~prop_q;
          state_d = StStream;
        end
      end
      StStream: begin
        if (beat_fire) begin
          if (last_beat) state_d = StDrain;
          else           cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      StDrain: begin
        if (tile_bad_dataflow_i) err_d = 1'b1;
        // A match in the expiry cycle wins and leaves err alone.
        if (out_match) begin
          state_d = StResp;
        end else if (wdog_expired) begin
          state_d = StResp;
          err_d   = 1'b1;
        end
      end
      StResp: begin
        if (done_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      prop_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      prop_q  <= prop_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tin_valid_q <= 1'b0;
      tin_a_q     <= '0;
      tin_b_q     <= '0;
      tin_d_q     <= '0;
      tin_ctrl_q  <= '0;
      tin_id_q    <= '0;
      tin_last_q  <= 1'b0;
    end else begin
      tin_valid_q <= beat_fire;
      if (beat_fire) begin
        tin_a_q              <= a_data_i;
        tin_b_q              <= bd_b_i;
        tin_d_q              <= bd_d_i;
        tin_ctrl_q.dataflow  <= cmd_q.dataflow;
        tin_ctrl_q.propagate <= prop_q;
        tin_ctrl_q.shift     <= cmd_q.shift;
        tin_id_q             <= cmd_q.id;
        tin_last_q           <= last_beat;
      end
    end
  end

  assign tile_in_valid_o     = tin_valid_q;
  assign tile_in_a_o         = tin_a_q;
  assign tile_in_b_o         = tin_b_q;
  assign tile_in_d_o         = tin_d_q;
  assign tile_in_dataflow_o  = tin_ctrl_q.dataflow;
  assign tile_in_propagate_o = tin_ctrl_q.propagate;
  assign tile_in_shift_o     = tin_ctrl_q.shift;
  assign tile_in_id_o        = tin_id_q;
  assign tile_in_last_o      = tin_last_q;

endmodule

// File: tb/tb_tile_feed_sequencer.sv
// Scoreboard bench for tile_feed_sequencer: stimulus queues expected beats/completions,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_tile_feed_sequencer;

  typedef struct packed {
    logic [7:0]  a;
    logic [19:0] b;
    logic [19:0] d;
    logic        df;
    logic        prop;
    logic [4:0]  shift;
    logic [2:0]  id;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [2:0] id;
    logic       err;
  } done_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_preload, cmd_dataflow;
  logic [4:0]  cmd_len, cmd_shift;
  logic [2:0]  cmd_id;
  logic        a_valid, a_ready, bd_valid, bd_ready;
  logic [7:0]  a_data;
  logic [19:0] bd_b, bd_d;
  logic        tile_in_valid, tile_in_dataflow, tile_in_propagate, tile_in_last;
  logic [7:0]  tile_in_a;
  logic [19:0] tile_in_b, tile_in_d;
  logic [4:0]  tile_in_shift;
  logic [2:0]  tile_in_id;
  logic        tile_out_valid, tile_out_last, tile_bad_dataflow;
  logic [2:0]  tile_out_id;
  logic        done_valid, done_ready, done_error, busy;
  logic [2:0]  done_id;

  always #5 clk = ~clk;

  tile_feed_sequencer dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .cmd_valid_i         (cmd_valid),
    .cmd_ready_o         (cmd_ready),
    .cmd_len_i           (cmd_len),
    .cmd_preload_i       (cmd_preload),
    .cmd_dataflow_i      (cmd_dataflow),
    .cmd_shift_i         (cmd_shift),
    .cmd_id_i            (cmd_id),
    .a_valid_i           (a_valid),
    .a_ready_o           (a_ready),
    .a_data_i            (a_data),
    .bd_valid_i          (bd_valid),
    .bd_ready_o          (bd_ready),
    .bd_b_i              (bd_b),
    .bd_d_i              (bd_d),
    .tile_in_valid_o     (tile_in_valid),
    .tile_in_a_o         (tile_in_a),
    .tile_in_b_o         (tile_in_b),
    .tile_in_d_o         (tile_in_d),
    .tile_in_dataflow_o  (tile_in_dataflow),
    .tile_in_propagate_o (tile_in_propagate),
    .tile_in_shift_o     (tile_in_shift),
    .tile_in_id_o        (tile_in_id),
    .tile_in_last_o      (tile_in_last),
    .tile_out_valid_i    (tile_out_valid),
    .tile_out_last_i     (tile_out_last),
    .tile_out_id_i       (tile_out_id),
    .tile_bad_dataflow_i (tile_bad_dataflow),
    .done_valid_o        (done_valid),
    .done_ready_i        (done_ready),
    .done_id_o           (done_id),
    .done_error_o        (done_error),
    .busy_o              (busy)
  );

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    cmd_edge, last_beat_cyc, done_rise_cyc;
  bit    prop_m;
  bit    done_prev;
  beat_t beat_q[$];
  done_t done_q[$];
  int    beat_cyc_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @cyc %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mk_a(input int base, input int i);
    return 8'(base + i);
  endfunction
  function automatic logic [19:0] mk_b(input int base, input int i);
    return 20'(base * 4096 + i * 17 + 3);
  endfunction
  function automatic logic [19:0] mk_d(input int base, input int i);
    return 20'(20'hFFFFF - base * 256 - i);
  endfunction

  // Monitor: beats and completions are compared in DUT order.
  always @(negedge clk) begin
    beat_t act_b, exp_b;
    done_t exp_d;
    if (rst_n && tile_in_valid) begin
      act_b = '{tile_in_a, tile_in_b, tile_in_d, tile_in_dataflow, tile_in_propagate,
                tile_in_shift, tile_in_id, tile_in_last};
      if (beat_q.size() == 0) begin
        chk("beat_unexpected", 64'(act_b), 64'(0));
      end else begin
        exp_b = beat_q.pop_front();
        chk("beat", 64'(act_b), 64'(exp_b));
      end
      beat_cyc_q.push_back(cyc);
      if (tile_in_last) last_beat_cyc = cyc;
    end
    if (done_valid && !done_prev) done_rise_cyc = cyc;
    done_prev = done_valid;
    if (rst_n && done_valid && done_ready) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 64'({done_id, done_error}), 64'(0));
      end else begin
        exp_d = done_q.pop_front();
        chk("done", 64'({done_id, done_error}), 64'(exp_d));
      end
    end
  end

  task automatic push_cmd(input int len, input bit pre, input bit df, input int sh, input int id,
                          input int base, input int nb, input bit with_done, input bit err);
    beat_t b;
    if (pre) prop_m = ~prop_m;
    for (int i = 0; i < nb; i++) begin
      b = '{mk_a(base, i), mk_b(base, i), mk_d(base, i), df, prop_m, 5'(sh), 3'(id), (i == len)};
      beat_q.push_back(b);
    end
    if (with_done) done_q.push_back('{3'(id), err});
  endtask

  task automatic issue_cmd(input int len, input bit pre, input bit df, input int sh, input int id);
    int w = 0;
    @(posedge clk); #1;
    cmd_len = 5'(len); cmd_preload = pre; cmd_dataflow = df; cmd_shift = 5'(sh); cmd_id = 3'(id);
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_accept", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_edge = cyc;
  endtask

  // Streams are driven independently of ready; stall mode drops a_valid every other cycle.
  task automatic feed(input int n, input int base, input bit stall);
    int i = 0;
    int t = 0;
    @(posedge clk); #1;
    while (i < n && t < 400) begin
      a_valid  = !stall || (t % 2 == 0);
      bd_valid = 1'b1;
      a_data   = mk_a(base, i);
      bd_b     = mk_b(base, i);
      bd_d     = mk_d(base, i);
      @(negedge clk);
      chk("ready_pair", 64'({a_ready, bd_ready}), 64'({2{a_ready & a_valid & bd_valid}}));
      if (a_ready) i++;
      @(posedge clk); #1;
      t++;
    end
    a_valid  = 1'b0;
    bd_valid = 1'b0;
    if (i < n) chk("feed_timeout", 64'(i), 64'(n));
  endtask

  task automatic tile_resp(input int id);
    @(posedge clk); #1;
    tile_out_valid = 1'b1; tile_out_last = 1'b1; tile_out_id = 3'(id);
    @(posedge clk); #1;
    tile_out_valid = 1'b0; tile_out_last = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (busy && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("idle", 64'(busy), 64'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, 64'({tile_in_valid, tile_in_a, tile_in_b, tile_in_d, tile_in_dataflow,
                   tile_in_propagate, tile_in_shift, tile_in_id, tile_in_last,
                   busy, done_valid}), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_outputs");
    prop_m = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    int gaps_bad;
    rst_n = 1'b0;
    cmd_valid = 0; cmd_len = 0; cmd_preload = 0; cmd_dataflow = 0; cmd_shift = 0; cmd_id = 0;
    a_valid = 0; a_data = 0; bd_valid = 0; bd_b = 0; bd_d = 0;
    tile_out_valid = 0; tile_out_last = 0; tile_out_id = 0; tile_bad_dataflow = 0;
    done_ready = 1'b1;
    prop_m = 1'b0;
    #1;
    check_reset_outputs("por_outputs");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: reset mid-stream with two beats issued (cnt=2)
    push_cmd(7, 1, 1, 9, 1, 16, 2, 0, 0);
    fork
      issue_cmd(7, 1, 1, 9, 1);
      feed(2, 16, 0);
    join
    do_reset();

    // 2: len=3 with preload from a freshly reset prop, streams always valid
    beat_cyc_q.delete();
    push_cmd(3, 1, 1, 4, 5, 32, 4, 1, 0);
    fork
      issue_cmd(3, 1, 1, 4, 5);
      feed(4, 32, 0);
    join
    tile_resp(5);
    wait_idle();
    chk("t2_beats", 64'(beat_cyc_q.size()), 64'(4));
    // beat registered at edge N+1 is the one the tile samples at edge N+2
    chk("t2_first_lat", 64'(beat_cyc_q[0]), 64'(cmd_edge + 1));
    chk("t2_last_lat", 64'(beat_cyc_q[3]), 64'(cmd_edge + 4));

    // 3: A stalls every other cycle, len=7
    beat_cyc_q.delete();
    push_cmd(7, 0, 0, 17, 2, 64, 8, 1, 0);
    fork
      issue_cmd(7, 0, 0, 17, 2);
      feed(8, 64, 1);
    join
    tile_resp(2);
    wait_idle();
    chk("t3_beats", 64'(beat_cyc_q.size()), 64'(8));
    gaps_bad = 0;
    for (int k = 1; k < beat_cyc_q.size(); k++)
      if (beat_cyc_q[k] - beat_cyc_q[k-1] != 2) gaps_bad++;
    chk("t3_gaps", 64'(gaps_bad), 64'(0));

    // 4: preload 1,1,0 from prop=0 -> propagate 1,0,0
    do_reset();
    push_cmd(1, 1, 0, 1, 1, 96, 2, 1, 0);
    fork issue_cmd(1, 1, 0, 1, 1); feed(2, 96, 0); join
    tile_resp(1);
    wait_idle();
    push_cmd(1, 1, 1, 2, 2, 112, 2, 1, 0);
    fork issue_cmd(1, 1, 1, 2, 2); feed(2, 112, 0); join
    tile_resp(2);
    wait_idle();
    push_cmd(1, 0, 0, 31, 3, 128, 2, 1, 0);
    fork issue_cmd(1, 0, 0, 31, 3); feed(2, 128, 0); join
    tile_resp(3);
    wait_idle();

    // 5: drain timeout, wrong-id last ignored
    push_cmd(2, 0, 1, 6, 5, 144, 3, 1, 1);
    fork issue_cmd(2, 0, 1, 6, 5); feed(3, 144, 0); join
    tile_resp(4);
    wait_idle();
    chk("t5_timeout_cyc", 64'(done_rise_cyc), 64'(last_beat_cyc + 64));

    // 6: bad dataflow then match; response held under backpressure
    done_ready = 1'b0;
    push_cmd(0, 0, 0, 3, 6, 160, 1, 1, 1);
    fork issue_cmd(0, 0, 0, 3, 6); feed(1, 160, 0); join
    @(posedge clk); #1;
    tile_bad_dataflow = 1'b1;
    @(posedge clk); #1;
    tile_bad_dataflow = 1'b0;
    tile_out_valid = 1'b1; tile_out_last = 1'b1; tile_out_id = 3'd6;
    @(posedge clk); #1;
    tile_out_valid = 1'b0; tile_out_last = 1'b0;
    for (int w = 0; w < 20 && !done_valid; w++) @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk("t6_hold", 64'({done_valid, done_id, done_error, cmd_ready}),
          64'({1'b1, 3'd6, 1'b1, 1'b0}));
      @(negedge clk);
    end
    @(posedge clk); #1;
    done_ready = 1'b1;
    wait_idle();

    chk("beat_q_empty", 64'(beat_q.size()), 64'(0));
    chk("done_q_empty", 64'(done_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
